// File: rtl/match_sched.sv
// Pair sequencer for star-ID matching: walks every (obs, nav) vector pair, issues
// vector RAM reads under credit flow control and presents a tag aligned with read data.
module match_sched #(
  parameter int OBS_VEC_NUM    = 49,
  parameter int NAV_VEC_NUM    = 539,
  parameter int NAV_ADDR_WIDTH = $clog2(NAV_VEC_NUM),
  parameter int OBS_ADDR_WIDTH = $clog2(OBS_VEC_NUM),
  parameter int RD_LAT         = 2,
  parameter int CREDITS        = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [OBS_ADDR_WIDTH:0]   obs_cnt,
  output logic                      busy,
  output logic                      done,
  output logic                      aborted,
  output logic                      rd_en,
  output logic [NAV_ADDR_WIDTH-1:0] rd_nav_addr,
  output logic [OBS_ADDR_WIDTH-1:0] rd_obs_addr,
  output logic                      tag_valid,
  output logic [NAV_ADDR_WIDTH-1:0] tag_nav_addr,
  output logic [OBS_ADDR_WIDTH-1:0] tag_obs_addr,
  output logic                      tag_first,
  output logic                      tag_last,
  input  logic                      credit_ret
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int CW         = $clog2(CREDITS + 1);
  localparam int TW         = NAV_ADDR_WIDTH + OBS_ADDR_WIDTH + 2;
  localparam int NAV_LAST_I = NAV_VEC_NUM - 1;
  localparam logic [NAV_ADDR_WIDTH-1:0] NAV_LAST  = NAV_LAST_I[NAV_ADDR_WIDTH-1:0];
  localparam logic [OBS_ADDR_WIDTH:0]   OBS_MAX   = OBS_VEC_NUM[OBS_ADDR_WIDTH:0];
  localparam logic [CW-1:0]             CRED_FULL = CREDITS[CW-1:0];

  logic [1:0]                state_q, state_d;
  logic [CW-1:0]             credit_q, credit_d;
  logic [NAV_ADDR_WIDTH-1:0] nav_q, nav_d;
  logic [OBS_ADDR_WIDTH-1:0] obs_q, obs_d;
  logic [OBS_ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [OBS_ADDR_WIDTH:0]   cnt_clamped;
  logic                      aborted_q;
  logic [RD_LAT-1:0]         vld_q;
  logic [TW-1:0]             tag_q [RD_LAT];

  logic abort_act;
  logic is_last;
  logic cr_accept;
  logic drain_empty;

  assign abort_act   = abort && (state_q != ST_IDLE);
  assign cnt_clamped = (obs_cnt > OBS_MAX) ? OBS_MAX : obs_cnt;
  assign is_last     = (nav_q == NAV_LAST) && ({1'b0, obs_q} == (cnt_q - 1'b1));

  // A pair is never issued in the abort cycle: it would only be squashed.
  assign rd_en       = (state_q == ST_RUN) && (credit_q != '0) && !abort;
  assign rd_nav_addr = nav_q;
  assign rd_obs_addr = obs_q;

  assign busy    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done    = (state_q == ST_DONE) && !abort;
  assign aborted = aborted_q;

  // Leave DRAIN once only the output stage can still hold a pair.
  generate
    if (RD_LAT > 1) begin : g_drain_multi
      assign drain_empty = ~|vld_q[RD_LAT-2:0];
    end else begin : g_drain_single
      assign drain_empty = 1'b1;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    nav_d   = nav_q;
    obs_d   = obs_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d   = cnt_clamped;
          nav_d   = '0;
          obs_d   = '0;
          state_d = (cnt_clamped == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (rd_en) begin
          if (is_last) begin
            nav_d   = '0;
            obs_d   = '0;
            state_d = ST_DRAIN;
          end else if (nav_q == NAV_LAST) begin
            nav_d = '0;
            obs_d = obs_q + 1'b1;
          end else begin
            nav_d = nav_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_empty) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort_act) begin
      state_d = ST_IDLE;
      nav_d   = '0;
      obs_d   = '0;
    end
  end

  assign cr_accept = credit_ret && ((credit_q != CRED_FULL) || rd_en);

  always_comb begin
    credit_d = credit_q;
    if (rd_en && !cr_accept) begin
      credit_d = credit_q - 1'b1;
    end else if (!rd_en && cr_accept) begin
      credit_d = credit_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      credit_q  <= CRED_FULL;
      nav_q     <= '0;
      obs_q     <= '0;
      cnt_q     <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      credit_q  <= credit_d;
      nav_q     <= nav_d;
      obs_q     <= obs_d;
      cnt_q     <= cnt_d;
      aborted_q <= abort_act;
    end
  end

  // Tag pipe mirrors the RAM read latency; abort clears every in-flight valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= rd_en && !abort_act;
      tag_q[0] <= {nav_q, obs_q, (nav_q == '0), is_last};
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1] && !abort_act;
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign tag_valid = vld_q[RD_LAT-1];
  assign {tag_nav_addr, tag_obs_addr, tag_first, tag_last} = tag_q[RD_LAT-1];

endmodule

// File: tb/tb_match_sched.sv
// Bench for match_sched: a pair-index model predicts every output each cycle,
// while directed scenarios pin issue counts, stalls, aborts and resets with literals.
module tb_match_sched;

  localparam int OBS  = 3;
  localparam int NAV  = 4;
  localparam int LAT  = 2;
  localparam int CRED = 4;
  localparam int OW   = $clog2(OBS);
  localparam int NW   = $clog2(NAV);

  localparam int P_IDLE  = 0;
  localparam int P_RUN   = 1;
  localparam int P_DRAIN = 2;
  localparam int P_DONE  = 3;

  logic          clk = 1'b0;
  logic          rst_n, start, abort, credit_ret;
  logic [OW:0]   obs_cnt;
  logic          busy, done, aborted, rd_en, tag_valid, tag_first, tag_last;
  logic [NW-1:0] rd_nav_addr, tag_nav_addr;
  logic [OW-1:0] rd_obs_addr, tag_obs_addr;

  always #5 clk = ~clk;

  match_sched #(
    .OBS_VEC_NUM(OBS),
    .NAV_VEC_NUM(NAV),
    .RD_LAT     (LAT),
    .CREDITS    (CRED)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .obs_cnt     (obs_cnt),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .rd_en       (rd_en),
    .rd_nav_addr (rd_nav_addr),
    .rd_obs_addr (rd_obs_addr),
    .tag_valid   (tag_valid),
    .tag_nav_addr(tag_nav_addr),
    .tag_obs_addr(tag_obs_addr),
    .tag_first   (tag_first),
    .tag_last    (tag_last),
    .credit_ret  (credit_ret)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", nm, $time, act, exp);
    end
  endtask

  // Model: a frame is a sequence of pair indices k = obs*NAV + nav.
  typedef struct {
    int due;
    int k;
    bit last;
  } tag_t;

  tag_t tq[$];
  int   m_phase, m_cred, m_k, m_total, cyc, oc;
  bit   m_aborted, m_known, e_rd, e_tv;
  int   n_rd, n_tag, n_done, n_abt, n_first, n_last;
  int   run_len, last_run, rd00_cyc, tag00_cyc, burst_nav, burst_obs;

  initial begin
    m_known = 0; cyc = 0; m_phase = P_IDLE; m_cred = CRED; m_k = 0; m_total = 0;
    m_aborted = 0; n_rd = 0; n_tag = 0; n_done = 0; n_abt = 0; n_first = 0; n_last = 0;
    run_len = 0; last_run = 0; rd00_cyc = 0; tag00_cyc = 0; burst_nav = -1; burst_obs = -1;
    forever begin
      @(negedge clk);
      e_rd = m_known && (m_phase == P_RUN) && (m_cred > 0) && !abort;
      if (m_known) begin
        chk("rd_en", rd_en, e_rd);
        chk("busy", busy, (m_phase == P_RUN) || (m_phase == P_DRAIN));
        chk("done", done, (m_phase == P_DONE) && !abort);
        chk("aborted", aborted, m_aborted);
        if (e_rd) begin
          chk("rd_nav_addr", rd_nav_addr, m_k % NAV);
          chk("rd_obs_addr", rd_obs_addr, m_k / NAV);
        end
        e_tv = (tq.size() > 0) && (tq[0].due == cyc);
        chk("tag_valid", tag_valid, e_tv);
        if (e_tv) begin
          chk("tag_nav_addr", tag_nav_addr, tq[0].k % NAV);
          chk("tag_obs_addr", tag_obs_addr, tq[0].k / NAV);
          chk("tag_first", tag_first, (tq[0].k % NAV) == 0);
          chk("tag_last", tag_last, tq[0].last);
          void'(tq.pop_front());
        end
        if (rd_en) begin
          n_rd++;
          if (run_len == 0) begin
            burst_nav = rd_nav_addr;
            burst_obs = rd_obs_addr;
          end
          run_len++;
          if (rd_nav_addr == 0 && rd_obs_addr == 0) rd00_cyc = cyc;
        end else if (run_len != 0) begin
          last_run = run_len;
          run_len  = 0;
        end
        if (tag_valid) begin
          n_tag++;
          if (tag_first) n_first++;
          if (tag_last) n_last++;
          if (tag_nav_addr == 0 && tag_obs_addr == 0) tag00_cyc = cyc;
          $display("tag cyc=%0d obs=%0d nav=%0d first=%0b last=%0b",
                   cyc, tag_obs_addr, tag_nav_addr, tag_first, tag_last);
        end
        if (done) n_done++;
        if (aborted) n_abt++;
      end
      if (!rst_n) begin
        m_phase = P_IDLE; m_cred = CRED; m_k = 0; m_total = 0; m_aborted = 0;
        tq.delete();
        m_known = 1;
      end else if (m_known) begin
        m_cred = m_cred - (e_rd ? 1 : 0) + (credit_ret ? 1 : 0);
        if (m_cred > CRED) m_cred = CRED;
        if (e_rd) begin
          tq.push_back('{cyc + LAT, m_k, m_k == m_total - 1});
          m_k++;
        end
        m_aborted = abort && (m_phase != P_IDLE);
        if (m_aborted) begin
          m_phase = P_IDLE;
          tq.delete();
        end else begin
          case (m_phase)
            P_IDLE: if (start) begin
              oc = int'(obs_cnt);
              if (oc > OBS) oc = OBS;
              m_total = oc * NAV;
              m_k     = 0;
              m_phase = (m_total == 0) ? P_DONE : P_RUN;
            end
            P_RUN:   if (m_k == m_total) m_phase = P_DRAIN;
            P_DRAIN: if (tq.size() == 0) m_phase = P_DONE;
            default: m_phase = P_IDLE;
          endcase
        end
      end
      cyc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int limit);
    int d0;
    int t;
    d0 = n_done;
    t  = 0;
    while (n_done == d0 && t < limit) begin
      step();
      t++;
    end
    if (n_done == d0) chk("done_timeout", 0, 1);
  endtask

  task automatic wait_rd(input int target, input int limit);
    int t;
    t = 0;
    while (n_rd < target && t < limit) begin
      step();
      t++;
    end
    if (n_rd < target) chk("rd_timeout", n_rd, target);
  endtask

  task automatic kick(input int cnt);
    start   = 1'b1;
    obs_cnt = cnt[OW:0];
    step();
    start   = 1'b0;
  endtask

  task automatic chk_idle_zero(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_aborted"}, aborted, 0);
    chk({nm, "_rd_en"}, rd_en, 0);
    chk({nm, "_tag_valid"}, tag_valid, 0);
    chk({nm, "_rd_nav"}, rd_nav_addr, 0);
    chk({nm, "_rd_obs"}, rd_obs_addr, 0);
  endtask

  int r0, t0, d0, a0, f0, l0, t1;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; credit_ret = 1'b0; obs_cnt = '0;
    repeat (2) step();
    rst_n = 1'b1;
    chk_idle_zero("reset");

    // Full frame with credits returned every cycle.
    credit_ret = 1'b1;
    r0 = n_rd; t0 = n_tag; d0 = n_done; f0 = n_first; l0 = n_last;
    kick(3);
    wait_done(60);
    repeat (2) step();
    chk("full_issues", n_rd - r0, 12);
    chk("full_tags", n_tag - t0, 12);
    chk("full_done", n_done - d0, 1);
    chk("full_contig", last_run, 12);
    chk("full_first", n_first - f0, 3);
    chk("full_last", n_last - l0, 1);
    chk("full_latency", tag00_cyc - rd00_cyc, 2);

    // Backpressure: four credits, then one returned credit, then continuous return.
    credit_ret = 1'b0;
    r0 = n_rd; d0 = n_done;
    kick(3);
    repeat (10) step();
    chk("bp_stall", n_rd - r0, 4);
    credit_ret = 1'b1;
    step();
    credit_ret = 1'b0;
    repeat (5) step();
    chk("bp_one_credit", n_rd - r0, 5);
    credit_ret = 1'b1;
    wait_done(60);
    repeat (2) step();
    chk("bp_total", n_rd - r0, 12);
    chk("bp_count1_contig", last_run, 7);
    chk("bp_done", n_done - d0, 1);

    // Empty frame completes the cycle after start; oversize count is clamped.
    r0 = n_rd; d0 = n_done;
    kick(0);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    step();
    chk("zero_done_end", done, 0);
    chk("zero_issues", n_rd - r0, 0);
    chk("zero_done_cnt", n_done - d0, 1);
    r0 = n_rd; l0 = n_last;
    kick(7);
    wait_done(60);
    repeat (2) step();
    chk("clamp_issues", n_rd - r0, 12);
    chk("clamp_contig", last_run, 12);
    chk("clamp_last", n_last - l0, 1);

    // Abort after five issues, then restart from (0,0).
    r0 = n_rd; d0 = n_done; a0 = n_abt;
    kick(3);
    wait_rd(r0 + 5, 20);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_pulse", aborted, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_rd_en", rd_en, 0);
    t1 = n_tag;
    repeat (6) step();
    chk("abort_no_tag", n_tag - t1, 0);
    chk("abort_issues", n_rd - r0, 5);
    chk("abort_no_done", n_done - d0, 0);
    chk("abort_cnt", n_abt - a0, 1);
    r0 = n_rd;
    kick(1);
    wait_done(30);
    repeat (2) step();
    chk("restart_issues", n_rd - r0, 4);
    chk("restart_nav0", burst_nav, 0);
    chk("restart_obs0", burst_obs, 0);

    // Reset while draining with the credit pool empty.
    credit_ret = 1'b0;
    r0 = n_rd; d0 = n_done;
    kick(1);
    wait_rd(r0 + 4, 20);
    chk("drain_busy", busy, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk_idle_zero("drain_reset");
    chk("drain_reset_first", tag_first, 0);
    chk("drain_reset_last", tag_last, 0);
    repeat (4) step();
    chk("drain_reset_no_done", n_done - d0, 0);
    r0 = n_rd;
    kick(3);
    repeat (10) step();
    chk("reset_credits", n_rd - r0, 4);
    credit_ret = 1'b1;
    wait_done(60);
    repeat (2) step();

    // credit_ret at a full pool together with start is ignored.
    r0 = n_rd; d0 = n_done;
    credit_ret = 1'b1;
    kick(3);
    credit_ret = 1'b0;
    repeat (10) step();
    chk("full_ret_ignored", n_rd - r0, 4);
    credit_ret = 1'b1;
    wait_done(60);
    repeat (2) step();
    chk("full_ret_total", n_rd - r0, 12);
    chk("full_ret_done", n_done - d0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog t=%0t got=running expected=finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
